// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 keyboard receiver. Synchronises and glitch-filters the PS/2 clock,
//   deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop), folds
//   E0/F0 prefix bytes into per-key flags, and queues {ext, brk, code} events
//   in a show-ahead FIFO that the consumer pops at its own pace.
//
// Ports
//   iClock        system clock, rising edge
//   iReset        asynchronous active-high reset
//   iPs2Clk       raw PS/2 clock pin
//   iPs2Data      raw PS/2 data pin
//   iRead         pop head entry (ignored while oValid=0)
//   oCode         head scan code, prefixes stripped
//   oExtended     head entry was preceded by E0
//   oBreak        head entry was preceded by F0
//   oValid        FIFO non-empty
//   oCount        entries held, 0..DEPTH
//   oParityError  1-cycle pulse, frame dropped for bad parity
//   oFrameError   1-cycle pulse, frame dropped for bad stop bit or timeout
//   oOverflow     1-cycle pulse, event dropped because the FIFO was full
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for a start bit (data low on a falling edge)
// S_DATA   | shifting in data bits 0..7
// S_PARITY | capturing the parity bit
// S_STOP   | capturing the stop bit and evaluating the frame

module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DEPTH          = 8
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iPs2Clk,
  input  logic                       iPs2Data,
  input  logic                       iRead,
  output logic [7:0]                 oCode,
  output logic                       oExtended,
  output logic                       oBreak,
  output logic                       oValid,
  output logic [$clog2(DEPTH):0]     oCount,
  output logic                       oParityError,
  output logic                       oFrameError,
  output logic                       oOverflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- input synchroniser and clock filter ----------------
  logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic          r_filt_clk;
  logic [FW-1:0] r_filt_cnt;
  logic          r_fall;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_meta <= iPs2Clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= iPs2Data;
      r_dat_sync <= r_dat_meta;
      r_fall     <= 1'b0;
      // Any sample matching the filtered level restarts the run, so only
      // FILTER_LEN consecutive differing samples flip the filtered clock.
      if (r_clk_sync != r_filt_clk) begin
        if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
          r_filt_clk <= r_clk_sync;
          r_filt_cnt <= '0;
          r_fall     <= r_filt_clk;
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  // ---------------- deframer ----------------
  state_t        r_state;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_timer;
  logic          r_ext, r_brk;
  logic          r_par_err, r_frm_err, r_ovf;

  // FIFO state (declared here because the push decision needs it)
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [9:0]    r_head;

  logic          w_frame_done, w_par_ok, w_stop_ok, w_good;
  logic          w_is_e0, w_is_f0, w_push, w_full, w_pop, w_wr_en, w_drop;
  logic [9:0]    w_entry;
  logic [AW-1:0] w_rd_nxt;
  logic [CW-1:0] w_cnt_after_pop;

  assign w_frame_done = r_fall && (r_state == S_STOP);
  assign w_par_ok     = ^{r_shift, r_par};
  assign w_stop_ok    = r_dat_sync;
  assign w_good       = w_frame_done && w_par_ok && w_stop_ok;
  assign w_is_e0      = (r_shift == 8'hE0);
  assign w_is_f0      = (r_shift == 8'hF0);
  assign w_push       = w_good && !w_is_e0 && !w_is_f0;
  assign w_entry      = {r_ext, r_brk, r_shift};

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_pop        = iRead && (r_count != '0);
  // A pop in the same cycle frees the slot the push needs.
  assign w_wr_en      = w_push && (!w_full || w_pop);
  assign w_drop       = w_push && w_full && !w_pop;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_timer   <= TW'(TIMEOUT_CYCLES - 1);
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovf     <= 1'b0;
      if (r_state == S_IDLE) begin
        r_timer <= TW'(TIMEOUT_CYCLES - 1);
        if (r_fall && !r_dat_sync) begin
          r_state <= S_DATA;
          r_idx   <= '0;
        end
      end else if (r_fall) begin
        r_timer <= TW'(TIMEOUT_CYCLES - 1);
        case (r_state)
          S_DATA: begin
            r_shift[r_idx] <= r_dat_sync;
            if (r_idx == 3'd7) r_state <= S_PARITY;
            else               r_idx   <= r_idx + 3'd1;
          end
          S_PARITY: begin
            r_par   <= r_dat_sync;
            r_state <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            // Parity failure takes precedence over a bad stop bit.
            if (!w_par_ok) begin
              r_par_err <= 1'b1;
              r_ext     <= 1'b0;
              r_brk     <= 1'b0;
            end else if (!w_stop_ok) begin
              r_frm_err <= 1'b1;
              r_ext     <= 1'b0;
              r_brk     <= 1'b0;
            end else if (w_is_e0) begin
              r_ext <= 1'b1;
            end else if (w_is_f0) begin
              r_brk <= 1'b1;
            end else begin
              r_ext <= 1'b0;
              r_brk <= 1'b0;
              r_ovf <= w_drop;
            end
          end
        endcase
      end else if (r_timer == '0) begin
        r_state   <= S_IDLE;
        r_frm_err <= 1'b1;
        r_ext     <= 1'b0;
        r_brk     <= 1'b0;
      end else begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  // ---------------- show-ahead FIFO ----------------
  assign w_rd_nxt        = r_rd_ptr + AW'(w_pop);
  assign w_cnt_after_pop = r_count - CW'(w_pop);

  always_ff @(posedge iClock) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= r_count + CW'(w_wr_en) - CW'(w_pop);
      // Head register tracks what the memory will hold at the new read
      // pointer; a push into an (effectively) empty FIFO bypasses memory.
      if (w_wr_en && (w_cnt_after_pop == '0)) r_head <= w_entry;
      else if (w_cnt_after_pop != '0)         r_head <= r_mem[w_rd_nxt];
    end
  end

  assign oCode        = r_head[7:0];
  assign oBreak       = r_head[8];
  assign oExtended    = r_head[9];
  assign oValid       = (r_count != '0);
  assign oCount       = r_count;
  assign oParityError = r_par_err;
  assign oFrameError  = r_frm_err;
  assign oOverflow    = r_ovf;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

  localparam int FL    = 8;
  localparam int TO    = 2000;
  localparam int DEPTH = 8;

  logic       iClock = 1'b0;
  logic       iReset = 1'b1;
  logic       iPs2Clk = 1'b1;
  logic       iPs2Data = 1'b1;
  logic       iRead = 1'b0;
  logic [7:0] oCode;
  logic       oExtended, oBreak, oValid;
  logic [3:0] oCount;
  logic       oParityError, oFrameError, oOverflow;

  int n_cmp = 0;
  int n_bad = 0;
  int n_par = 0;
  int n_frm = 0;
  int n_ovf = 0;
  int p0, f0, o0;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .DEPTH(DEPTH)) dut (
    .iClock(iClock), .iReset(iReset), .iPs2Clk(iPs2Clk), .iPs2Data(iPs2Data),
    .iRead(iRead), .oCode(oCode), .oExtended(oExtended), .oBreak(oBreak),
    .oValid(oValid), .oCount(oCount), .oParityError(oParityError),
    .oFrameError(oFrameError), .oOverflow(oOverflow)
  );

  always #5 iClock = ~iClock;

  always @(negedge iClock) begin
    if (oParityError === 1'b1) n_par++;
    if (oFrameError === 1'b1)  n_frm++;
    if (oOverflow === 1'b1)    n_ovf++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    chk({tag, ".valid"}, 32'(oValid), 32'd1);
    chk({tag, ".code"}, 32'(oCode), 32'(code));
    chk({tag, ".ext"}, 32'(oExtended), 32'(ext));
    chk({tag, ".brk"}, 32'(oBreak), 32'(brk));
  endtask

  task automatic pop();
    iRead = 1'b1;
    cyc(1);
    iRead = 1'b0;
    cyc(1);
  endtask

  task automatic snap();
    p0 = n_par; f0 = n_frm; o0 = n_ovf;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par, input logic stop_bit,
                      input logic glitch, input logic pop_at_stop, input int nbits);
    logic [10:0] f;
    f = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      iPs2Data = f[i];
      if (glitch) begin
        cyc(3); iPs2Clk = 1'b0; cyc(3); iPs2Clk = 1'b1; cyc(4);
      end else begin
        cyc(10);
      end
      iPs2Clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        cyc(FL + 2); iRead = 1'b1; cyc(1); iRead = 1'b0; cyc(20 - FL - 3);
      end else if (glitch) begin
        cyc(12); iPs2Clk = 1'b1; cyc(3); iPs2Clk = 1'b0; cyc(5);
      end else begin
        cyc(20);
      end
      iPs2Clk = 1'b1;
      cyc(10);
    end
    iPs2Data = 1'b1;
    cyc(10);
  endtask

  task automatic sendb(input logic [7:0] b);
    send(b, 1'b0, 1'b1, 1'b0, 1'b0, 11);
  endtask

  initial begin
    cyc(3);
    iReset = 1'b0;
    cyc(2);
    chk("rst.valid", 32'(oValid), 0);
    chk("rst.count", 32'(oCount), 0);
    chk("rst.code", 32'(oCode), 0);
    chk("rst.ext_brk", 32'({oExtended, oBreak}), 0);
    chk("rst.pulses", 32'({oParityError, oFrameError, oOverflow}), 0);

    // Plain make code
    sendb(8'h1C);
    head("a", 8'h1C, 1'b0, 1'b0);
    chk("a.count", 32'(oCount), 1);
    pop();
    chk("a.pop_valid", 32'(oValid), 0);
    chk("a.pop_count", 32'(oCount), 0);

    // Break prefix
    sendb(8'hF0); sendb(8'h1C);
    chk("brk.count", 32'(oCount), 1);
    head("brk", 8'h1C, 1'b0, 1'b1);
    pop();

    // Extended break
    sendb(8'hE0); sendb(8'hF0); sendb(8'h75);
    chk("extbrk.count", 32'(oCount), 1);
    head("extbrk", 8'h75, 1'b1, 1'b1);
    pop();
    sendb(8'h1C);
    head("flagclr", 8'h1C, 1'b0, 1'b0);
    pop();

    // Bad parity after an E0 prefix: frame dropped, flags cleared
    sendb(8'hE0);
    snap();
    send(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 11);
    chk("par.pulses", 32'(n_par - p0), 1);
    chk("par.frm", 32'(n_frm - f0), 0);
    chk("par.count", 32'(oCount), 0);
    sendb(8'hF0); sendb(8'h1C);
    head("par.next", 8'h1C, 1'b0, 1'b1);
    pop();

    // Bad stop bit, then both bad
    snap();
    send(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 11);
    chk("stop.frm", 32'(n_frm - f0), 1);
    chk("stop.par", 32'(n_par - p0), 0);
    chk("stop.count", 32'(oCount), 0);
    snap();
    send(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 11);
    chk("both.par", 32'(n_par - p0), 1);
    chk("both.frm", 32'(n_frm - f0), 0);

    // Timeout mid-frame after an E0 prefix
    sendb(8'hE0);
    snap();
    send(8'h29, 1'b0, 1'b1, 1'b0, 1'b0, 5);
    cyc(TO + 100);
    chk("to.frm", 32'(n_frm - f0), 1);
    chk("to.count", 32'(oCount), 0);
    sendb(8'h29);
    head("to.next", 8'h29, 1'b0, 1'b0);
    pop();

    // Overflow
    snap();
    for (int i = 1; i <= 9; i++) sendb(8'(i));
    chk("ovf.count", 32'(oCount), DEPTH);
    chk("ovf.pulses", 32'(n_ovf - o0), 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf.pop%0d", i), 32'(oCode), 32'(i));
      pop();
    end
    chk("ovf.empty", 32'(oValid), 0);

    // Glitches on the PS/2 clock
    snap();
    send(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 11);
    head("glitch", 8'h5A, 1'b0, 1'b0);
    chk("glitch.count", 32'(oCount), 1);
    chk("glitch.errs", 32'((n_par - p0) + (n_frm - f0)), 0);
    pop();

    // Push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) sendb(8'h10 + 8'(i));
    chk("pp.fill", 32'(oCount), DEPTH);
    snap();
    send(8'h18, 1'b0, 1'b1, 1'b0, 1'b1, 11);
    chk("pp.count", 32'(oCount), DEPTH);
    chk("pp.ovf", 32'(n_ovf - o0), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp.pop%0d", i), 32'(oCode), 32'h11 + 32'(i));
      pop();
    end
    chk("pp.empty", 32'(oCount), 0);

    // Reset in the middle of a frame with a non-empty FIFO
    sendb(8'h1C);
    send(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    iReset = 1'b1;
    cyc(2);
    iReset = 1'b0;
    cyc(1);
    chk("mrst.count", 32'(oCount), 0);
    chk("mrst.valid", 32'(oValid), 0);
    chk("mrst.pulses", 32'({oParityError, oFrameError, oOverflow}), 0);
    sendb(8'h29);
    head("mrst.next", 8'h29, 1'b0, 1'b0);
    chk("mrst.next_count", 32'(oCount), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver, the successor to the first-generation keyboard decoder.
- Oversamples the PS/2 clock and data lines in the system clock domain, filters glitches, and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Folds E0/F0 prefixes into per-key flags and queues decoded key events in a show-ahead FIFO.
- Sits between the PS/2 pins and the movement/command logic, which pops events at its own pace.

Parameters:
FILTER_LEN, 8, consecutive system cycles the synchronised PS/2 clock must hold a level before the filtered clock changes (>=2).
TIMEOUT_CYCLES, 50000, system cycles with no filtered falling edge mid-frame before the frame is abandoned.
DEPTH, 8, FIFO entries; power of two, >=2.

Ports:
iClock  input  1  system clock, all logic on rising edge
iReset  input  1  asynchronous, active-high reset
iPs2Clk  input  1  raw PS/2 clock pin
iPs2Data  input  1  raw PS/2 data pin
iRead  input  1  pop head entry; ignored when oValid=0
oCode  output  8  head scan code (make code, prefix bytes stripped)
oExtended  output  1  head entry was preceded by E0
oBreak  output  1  head entry was preceded by F0 (key release)
oValid  output  1  FIFO non-empty; oCode/oExtended/oBreak meaningful
oCount  output  $clog2(DEPTH)+1  entries held
oParityError  output  1  one-cycle pulse: frame discarded, bad parity
oFrameError  output  1  one-cycle pulse: frame discarded, bad stop bit or timeout
oOverflow  output  1  one-cycle pulse: event dropped, FIFO full

Behaviour:
- Reset (async, active-high): all outputs 0, FSM IDLE, FIFO empty, prefix flags clear, filter state = 1 (bus idle high).
- Input path: 2-FF synchroniser on both pins. The filter counter tracks the synchronised clock; the filtered clock toggles after FILTER_LEN equal samples differing from its current value. Edge pulse = filtered 1->0, one cycle wide. Data is sampled from the synchronised data line in the edge-pulse cycle.
- FSM, advancing only on edge pulses unless noted:
  - IDLE: data=0 -> DATA, bit index=0. Data=1 -> stay (no error).
  - DATA: shift bit into shift[index]; index 7 -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: evaluate frame -> IDLE.
  - Timeout: in DATA/PARITY/STOP, a counter counts cycles since the last edge. Reaching TIMEOUT_CYCLES -> IDLE, pulse oFrameError, prefix flags cleared. The counter resets on every edge and in IDLE.
- Frame evaluation, in the STOP edge cycle N:
  - Parity check: XOR of the 8 data bits and the parity bit must equal 1. On failure, pulse oParityError in N+1 and clear prefix flags.
  - Stop check: stop bit must be 1. If it is 0, pulse oFrameError in N+1 and clear prefix flags.
  - If both fail, only oParityError pulses.
  - Good byte E0: set ext flag, no push.
  - Good byte F0: set brk flag, no push.
  - Any other good byte: push {ext, brk, byte} at the end of cycle N and clear both flags. oValid and the head fields reflect the entry from N+1 when the FIFO was empty.
- FIFO:
  - Show-ahead; head fields are registered.
  - A pop on iRead=1 with oValid=1 takes effect at the clock edge, and the next entry appears the following cycle.
  - Push when full and no pop in the same cycle: drop the event, pulse oOverflow, clear flags. Stored contents are unchanged.
  - Simultaneous push and pop when full: both succeed; oCount unchanged.
  - Simultaneous push and pop when empty: the push is stored, and the pop is ignored because oValid=0.
  - Pointers wrap modulo DEPTH. oCount ranges 0..DEPTH.
- Mid-operation reset: the frame is lost, the FIFO empties, and all pulse outputs are low on the first cycle after release.
- Emitted code byte range 00..FF excluding E0/F0.

Test Plan:
- Frame 0x1C (A), parity 0, stop 1 -> one entry: oCode=1C, oExtended=0, oBreak=0, oCount=1. iRead pop -> oValid=0.
- Bytes F0,1C -> single entry {brk=1, code=1C}. Bytes E0,F0,75 -> single entry {ext=1, brk=1, code=75}, flags clear afterwards.
- 0x1C with parity bit 1 -> oParityError pulse exactly 1 cycle, no entry. The following F0,1C yields brk=1, and the preceding bad frame must not leave stale flags.
- Clock line stops after 4 data bits for TIMEOUT_CYCLES -> oFrameError pulse, FSM IDLE. The next full 0x29 frame is received correctly.
- DEPTH=8: send 9 codes 01..09 without reads -> oCount=8, oOverflow on the 9th, head=01. Pops return 01..08 in order.
- Glitch pulses on iPs2Clk shorter than FILTER_LEN during a frame -> ignored; code received intact. Pop on the same cycle as a push with the FIFO full -> oCount stays 8, no overflow.
